// File: rtl/if_id_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_ctrl_if : IF <-> ID fetch/redirect channel   | Rev 1.0      |
// +------------------------------------------------------------------+
interface if_id_ctrl_if;
    logic [31:0] Instruction_if;
    logic [31:0] PC;
    logic        IF_flush;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic        IFWrite;

    modport master (
        output Instruction_if, PC, IF_flush,
        input  Branch, Jump, JumpAddr, IFWrite
    );

    modport slave (
        input  Instruction_if, PC, IF_flush,
        output Branch, Jump, JumpAddr, IFWrite
    );
endinterface
`default_nettype wire

// File: rtl/if_id_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_ctrl : IF/ID register, jump/branch resolve, load-use stall  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module if_id_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    if_id_ctrl_if.slave      ifc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             id_bubble,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_instr;
    logic [31:0]      r_pc;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_hazard;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic        w_take;
    logic        w_branch;
    logic        w_jump;
    logic [31:0] w_target;
    logic        w_redirect;

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

    assign w_rs1_used = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                          (w_opcode == c_OP_JAL));
    assign w_rs2_used = (w_opcode == c_OP_BRANCH) || (w_opcode == c_OP_STORE) ||
                        (w_opcode == c_OP_OP);

    assign w_hazard = r_valid && ex_MemRead && (ex_rd != 5'd0) &&
                      ((w_rs1_used && (ex_rd == w_rs1)) ||
                       (w_rs2_used && (ex_rd == w_rs2)));

    assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_j = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_imm_b = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};

    always_comb begin
        w_take = 1'b0;
        case (w_funct3)
            3'b000:  w_take = (rs1_data == rs2_data);
            3'b001:  w_take = (rs1_data != rs2_data);
            3'b100:  w_take = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  w_take = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  w_take = (rs1_data <  rs2_data);
            3'b111:  w_take = (rs1_data >= rs2_data);
            default: w_take = 1'b0;
        endcase
    end

    // A stalled control instruction stays quiet; it re-resolves once the hazard clears.
    always_comb begin
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_target = 32'd0;
        if (r_valid && !w_hazard) begin
            case (w_opcode)
                c_OP_JAL: begin
                    w_jump   = 1'b1;
                    w_target = r_pc + w_imm_j;
                end
                c_OP_JALR: begin
                    w_jump   = 1'b1;
                    w_target = (rs1_data + w_imm_i) & 32'hFFFF_FFFE;
                end
                c_OP_BRANCH: begin
                    if (w_take) begin
                        w_branch = 1'b1;
                        w_target = r_pc + w_imm_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_redirect = w_branch | w_jump;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr     <= NOP_INSTR;
            r_pc        <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (r_flush_cnt != c_CNT_MAX) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end else if (w_hazard) begin
            if (r_stall_cnt != c_CNT_MAX) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end else if (ifc.IF_flush) begin
            r_instr <= ifc.Instruction_if;
            r_pc    <= ifc.PC;
            r_valid <= 1'b1;
        end
    end

    assign ifc.Branch   = w_branch;
    assign ifc.Jump     = w_jump;
    assign ifc.JumpAddr = w_target;
    assign ifc.IFWrite  = ~w_hazard;

    assign id_instr  = r_instr;
    assign id_pc     = r_pc;
    assign id_valid  = r_valid;
    assign id_bubble = w_hazard | ~r_valid;
    assign rs1_addr  = w_rs1;
    assign rs2_addr  = w_rs2;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_if_id_ctrl : directed vectors for if_id_ctrl    | Rev 1.0      |
// +------------------------------------------------------------------+
module tb_if_id_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_MemRead;
    logic [4:0]  ex_rd;

    logic [31:0] id_instr, id_pc;
    logic        id_valid, id_bubble;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_id_instr, s_id_pc;
    logic        s_id_valid, s_id_bubble;
    logic [4:0]  s_rs1_addr, s_rs2_addr;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    if_id_ctrl_if bus ();
    if_id_ctrl_if bus_s ();

    assign bus_s.Instruction_if = bus.Instruction_if;
    assign bus_s.PC             = bus.PC;
    assign bus_s.IF_flush       = bus.IF_flush;

    if_id_ctrl #(.NOP_INSTR(32'h00000013), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .ifc(bus),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .id_bubble(id_bubble),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_ctrl #(.NOP_INSTR(32'h00000013), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .ifc(bus_s),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
        .id_instr(s_id_instr), .id_pc(s_id_pc), .id_valid(s_id_valid), .id_bubble(s_id_bubble),
        .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        bus.Instruction_if = instr;
        bus.PC             = pc;
        bus.IF_flush       = 1'b1;
        tick();
        bus.IF_flush       = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; rs1_data = '0; rs2_data = '0; ex_MemRead = 1'b0; ex_rd = '0;
        bus.Instruction_if = 32'h00000013; bus.PC = '0; bus.IF_flush = 1'b0;

        // reset state
        tick(); tick(); #1;
        check("rst_instr",  id_instr, 32'h00000013);
        check("rst_pc",     id_pc, 32'h0);
        check("rst_valid",  {31'd0, id_valid}, 32'd0);
        check("rst_branch", {31'd0, bus.Branch}, 32'd0);
        check("rst_jump",   {31'd0, bus.Jump}, 32'd0);
        check("rst_jaddr",  bus.JumpAddr, 32'h0);
        check("rst_ifw",    {31'd0, bus.IFWrite}, 32'd1);
        check("rst_bubble", {31'd0, id_bubble}, 32'd1);
        check("rst_stall",  {16'd0, stall_cnt}, 32'd0);
        check("rst_flush",  {16'd0, flush_cnt}, 32'd0);
        reset = 1'b1;

        // JAL +8 from 0x10
        load(32'h0080006F, 32'h10);
        check("jal_jump",   {31'd0, bus.Jump}, 32'd1);
        check("jal_addr",   bus.JumpAddr, 32'h18);
        check("jal_valid",  {31'd0, id_valid}, 32'd1);
        check("jal_bubble", {31'd0, id_bubble}, 32'd0);
        check("jal_pc",     id_pc, 32'h10);
        bus.Instruction_if = 32'h00000033; bus.PC = 32'h14; bus.IF_flush = 1'b1;
        tick(); bus.IF_flush = 1'b0; #1;
        check("jal_flush_valid", {31'd0, id_valid}, 32'd0);
        check("jal_flush_cnt",   {16'd0, flush_cnt}, 32'd1);
        check("jal_flush_instr", id_instr, 32'h00000013);
        check("jal_flush_jump",  {31'd0, bus.Jump}, 32'd0);
        check("jal_flush_bub",   {31'd0, id_bubble}, 32'd1);

        // BEQ x1,x2,-4 at 0x20
        rs1_data = 32'd5; rs2_data = 32'd5;
        load(32'hFE208EE3, 32'h20);
        check("beq_t_branch", {31'd0, bus.Branch}, 32'd1);
        check("beq_t_addr",   bus.JumpAddr, 32'h1C);
        check("beq_rs1a",     {27'd0, rs1_addr}, 32'd1);
        check("beq_rs2a",     {27'd0, rs2_addr}, 32'd2);
        rs2_data = 32'd6; #1;
        check("beq_n_branch", {31'd0, bus.Branch}, 32'd0);
        check("beq_n_addr",   bus.JumpAddr, 32'h0);
        tick(); #1;
        check("beq_n_hold",   {31'd0, id_valid}, 32'd1);
        check("beq_n_flush",  {16'd0, flush_cnt}, 32'd1);

        // funct3=010 never takes
        load(32'hFE20AEE3, 32'h30);
        rs2_data = 32'd5; #1;
        check("f010_branch", {31'd0, bus.Branch}, 32'd0);
        check("f010_addr",   bus.JumpAddr, 32'h0);

        // signed vs unsigned
        rs1_data = 32'hFFFFFFFF; rs2_data = 32'd1;
        load(32'hFE20CEE3, 32'h40);
        check("blt_branch", {31'd0, bus.Branch}, 32'd1);
        check("blt_addr",   bus.JumpAddr, 32'h3C);
        tick(); #1;
        check("blt_flush",  {16'd0, flush_cnt}, 32'd2);
        check("blt_valid",  {31'd0, id_valid}, 32'd0);
        load(32'hFE20EEE3, 32'h50);
        check("bltu_branch", {31'd0, bus.Branch}, 32'd0);
        check("bltu_addr",   bus.JumpAddr, 32'h0);

        // JALR x0,0(x1), bit 0 cleared
        load(32'h00008067, 32'h60);
        rs1_data = 32'h101; #1;
        check("jalr_jump", {31'd0, bus.Jump}, 32'd1);
        check("jalr_addr", bus.JumpAddr, 32'h100);
        tick(); #1;
        check("jalr_flush", {16'd0, flush_cnt}, 32'd3);

        // load-use on add x6,x5,x7
        rs1_data = '0; rs2_data = '0;
        load(32'h00728333, 32'h70);
        ex_MemRead = 1'b1; ex_rd = 5'd5; #1;
        check("lu_ifw",    {31'd0, bus.IFWrite}, 32'd0);
        check("lu_bubble", {31'd0, id_bubble}, 32'd1);
        tick(); #1;
        check("lu_stall",  {16'd0, stall_cnt}, 32'd1);
        check("lu_sstall", {30'd0, s_stall_cnt}, 32'd1);
        check("lu_instr",  id_instr, 32'h00728333);
        check("lu_pc",     id_pc, 32'h70);
        ex_rd = 5'd0; #1;
        check("lu_x0_ifw", {31'd0, bus.IFWrite}, 32'd1);
        check("lu_x0_bub", {31'd0, id_bubble}, 32'd0);
        ex_rd = 5'd7; #1;
        check("lu_rs2_ifw", {31'd0, bus.IFWrite}, 32'd0);
        ex_MemRead = 1'b0; ex_rd = 5'd0;

        // stall before branch
        rs1_data = 32'd5; rs2_data = 32'd5;
        load(32'hFE208EE3, 32'h80);
        ex_MemRead = 1'b1; ex_rd = 5'd1; #1;
        check("sb_branch", {31'd0, bus.Branch}, 32'd0);
        check("sb_ifw",    {31'd0, bus.IFWrite}, 32'd0);
        check("sb_addr",   bus.JumpAddr, 32'h0);
        tick(); ex_MemRead = 1'b0; #1;
        check("sb_stall",   {16'd0, stall_cnt}, 32'd2);
        check("sb_branch2", {31'd0, bus.Branch}, 32'd1);
        check("sb_addr2",   bus.JumpAddr, 32'h7C);
        check("sb_ifw2",    {31'd0, bus.IFWrite}, 32'd1);
        tick(); #1;
        check("sb_flush",   {16'd0, flush_cnt}, 32'd4);
        check("sb_sflush",  {30'd0, s_flush_cnt}, 32'd3);

        // counter saturation with a 5-cycle stall
        load(32'h00728333, 32'h90);
        ex_MemRead = 1'b1; ex_rd = 5'd5;
        repeat (5) tick();
        #1;
        check("sat_sstall", {30'd0, s_stall_cnt}, 32'd3);
        check("sat_stall",  {16'd0, stall_cnt}, 32'd7);
        check("sat_instr",  id_instr, 32'h00728333);
        check("sat_pc",     id_pc, 32'h90);

        // reset in the middle of a stall
        reset = 1'b0;
        tick(); #1;
        check("rst2_valid",  {31'd0, id_valid}, 32'd0);
        check("rst2_instr",  id_instr, 32'h00000013);
        check("rst2_pc",     id_pc, 32'h0);
        check("rst2_stall",  {16'd0, stall_cnt}, 32'd0);
        check("rst2_flush",  {16'd0, flush_cnt}, 32'd0);
        check("rst2_ifw",    {31'd0, bus.IFWrite}, 32'd1);
        check("rst2_bubble", {31'd0, id_bubble}, 32'd1);
        check("rst2_sstall", {30'd0, s_stall_cnt}, 32'd0);
        reset = 1'b1;
        ex_MemRead = 1'b0; ex_rd = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
